// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access unit: op fields, sizes, FSM states.
package dm_pkg;

    localparam int DM_NMEM     = 256;
    localparam int OP_STORE    = 3;
    localparam int OP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } dm_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_WR,
        ST_DONE
    } dm_state_e;

endpackage

// File: rtl/dm_lane_merge.sv
// Little-endian lane handling: merges store data into an old word and
// extracts/extends a load value from the same word.
module dm_lane_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  dm_size_e    size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged   = old_word;
        load_val = old_word;
        byte_sel = old_word[{offset, 3'b000} +: 8];
        half_sel = old_word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged[{offset, 3'b000} +: 8] = new_data[7:0];
                load_val = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
                load_val = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                merged   = new_data;
                load_val = old_word;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage initiator for the word-addressed data memory: byte/half/word
// loads and stores, sub-word stores done as read-modify-write.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int NMEM = DM_NMEM,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] dm_addr,
    output logic          dm_ctrl_r,
    output logic          dm_ctrl_w,
    output logic [31:0]   dm_wdata,
    input  logic [31:0]   dm_rdata
);

    localparam logic [31:0] NMEM_W = 32'(NMEM);

    dm_state_e     state_q, state_d;
    logic          store_q, store_d;
    logic          uns_q, uns_d;
    dm_size_e      size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic          dm_ctrl_r_q, dm_ctrl_r_d;
    logic          dm_ctrl_w_q, dm_ctrl_w_d;
    logic [31:0]   dm_wdata_q, dm_wdata_d;

    dm_size_e      req_size;
    logic          acc_err;
    logic [31:0]   merged_word;
    logic [31:0]   load_val;

    dm_lane_merge u_lane_merge (
        .old_word    (dm_rdata),
        .new_data    (wdata_q),
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .merged      (merged_word),
        .load_val    (load_val)
    );

    // The word-index bound also covers every address bit above the dm index.
    always_comb begin
        req_size = dm_size_e'(req_op[1:0]);
        acc_err  = (req_size == SZ_ILL)
                 | ((req_size == SZ_HALF) && req_addr[0])
                 | ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 | ({2'b00, req_addr[31:2]} >= NMEM_W);
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        uns_d        = uns_q;
        size_d       = size_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        dm_addr_d    = dm_addr_q;
        dm_ctrl_r_d  = 1'b0;
        dm_ctrl_w_d  = 1'b0;
        dm_wdata_d   = dm_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d   = req_op[OP_STORE];
                    uns_d     = req_op[OP_UNSIGNED];
                    size_d    = req_size;
                    off_d     = req_addr[1:0];
                    wdata_d   = req_wdata;
                    dm_addr_d = req_addr[AW+1:2];
                    if (acc_err) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (req_op[OP_STORE] && (req_size == SZ_WORD)) begin
                        state_d     = ST_WR;
                        dm_ctrl_w_d = 1'b1;
                        dm_wdata_d  = req_wdata;
                    end else begin
                        state_d     = ST_RD_REQ;
                        dm_ctrl_r_d = 1'b1;
                    end
                end
            end
            ST_RD_REQ: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (store_q) begin
                    state_d     = ST_WR;
                    dm_ctrl_w_d = 1'b1;
                    dm_wdata_d  = merged_word;
                end else begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_val;
                end
            end
            ST_WR: begin
                state_d      = ST_DONE;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= SZ_BYTE;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            dm_addr_q    <= '0;
            dm_ctrl_r_q  <= 1'b0;
            dm_ctrl_w_q  <= 1'b0;
            dm_wdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            uns_q        <= uns_d;
            size_q       <= size_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            dm_addr_q    <= dm_addr_d;
            dm_ctrl_r_q  <= dm_ctrl_r_d;
            dm_ctrl_w_q  <= dm_ctrl_w_d;
            dm_wdata_q   <= dm_wdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign dm_addr    = dm_addr_q;
    assign dm_ctrl_r  = dm_ctrl_r_q;
    assign dm_ctrl_w  = dm_ctrl_w_q;
    assign dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a small synchronous dm model.
module tb_dm_access_unit;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_ILL = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  dm_addr;
    logic        dm_ctrl_r;
    logic        dm_ctrl_w;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    int          r_cyc, w_cyc, v_cyc, r_cnt, w_cnt, both_cnt;
    logic [31:0] got_rd;
    logic        got_err;
    logic [7:0]  r_addr_s, w_addr_s;

    dm_access_unit #(.NMEM(256), .AW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_ctrl_r  (dm_ctrl_r),
        .dm_ctrl_w  (dm_ctrl_w),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_ctrl_w) mem[dm_addr] <= dm_wdata;
        if (dm_ctrl_r) dm_rdata <= mem[dm_addr];
    end

    // Issues one request and records per-cycle observations; cycle 1 is the
    // cycle right after the accepting posedge.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int guard;
        guard = 0;
        r_cyc = -1; w_cyc = -1; v_cyc = -1;
        r_cnt = 0; w_cnt = 0; both_cnt = 0;
        got_rd = 32'hxxxxxxxx; got_err = 1'bx;
        r_addr_s = 8'hxx; w_addr_s = 8'hxx;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (dm_ctrl_r) begin r_cnt++; if (r_cyc < 0) r_cyc = k; r_addr_s = dm_addr; end
            if (dm_ctrl_w) begin w_cnt++; if (w_cyc < 0) w_cyc = k; w_addr_s = dm_addr; end
            if (dm_ctrl_r && dm_ctrl_w) both_cnt++;
            if (resp_valid) begin
                v_cyc = k; got_rd = resp_rdata; got_err = resp_err;
                break;
            end
        end
        $display("req op=%h addr=%h wd=%h : r_cyc=%0d w_cyc=%0d v_cyc=%0d rdata=%h err=%b",
                 op, addr, wd, r_cyc, w_cyc, v_cyc, got_rd, got_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if (dm_ctrl_r !== 1'b0 || dm_ctrl_w !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", dm_ctrl_r, dm_ctrl_w); end
        checks++; if (dm_addr !== 8'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", dm_addr); end
        checks++; if (dm_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", dm_wdata); end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_sw_lw();
        do_req(OP_SW, 32'h10, 32'hDEADBEEF);
        checks++; if (w_cyc !== 1 || w_cnt !== 1) begin errors++; $display("FAIL sw_wcyc got=%0d/%0d exp=1/1", w_cyc, w_cnt); end
        checks++; if (w_addr_s !== 8'd4) begin errors++; $display("FAIL sw_addr got=%h exp=04", w_addr_s); end
        checks++; if (r_cnt !== 0) begin errors++; $display("FAIL sw_no_read got=%0d exp=0", r_cnt); end
        checks++; if (v_cyc !== 2 || got_err !== 1'b0) begin errors++; $display("FAIL sw_resp got=%0d/%b exp=2/0", v_cyc, got_err); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
        do_req(OP_LW, 32'h10, 32'h0);
        checks++; if (r_cyc !== 1 || r_cnt !== 1 || w_cnt !== 0) begin errors++; $display("FAIL lw_strobes got=%0d/%0d/%0d exp=1/1/0", r_cyc, r_cnt, w_cnt); end
        checks++; if (v_cyc !== 3) begin errors++; $display("FAIL lw_cyc got=%0d exp=3", v_cyc); end
        checks++; if (got_rd !== 32'hDEADBEEF || got_err !== 1'b0) begin errors++; $display("FAIL lw_data got=%h/%b exp=deadbeef/0", got_rd, got_err); end
    endtask

    task automatic test_sb_rmw();
        do_req(OP_SB, 32'h11, 32'hFFFFFF55);
        checks++; if (r_cyc !== 1 || w_cyc !== 3) begin errors++; $display("FAIL sb_order got=r%0d w%0d exp=r1 w3", r_cyc, w_cyc); end
        checks++; if (r_cnt !== 1 || w_cnt !== 1 || both_cnt !== 0) begin errors++; $display("FAIL sb_counts got=%0d/%0d/%0d exp=1/1/0", r_cnt, w_cnt, both_cnt); end
        checks++; if (r_addr_s !== 8'd4 || w_addr_s !== 8'd4) begin errors++; $display("FAIL sb_addr got=%h/%h exp=04/04", r_addr_s, w_addr_s); end
        checks++; if (v_cyc !== 4 || got_rd !== 32'h0) begin errors++; $display("FAIL sb_resp got=%0d/%h exp=4/0", v_cyc, got_rd); end
        checks++; if (mem[4] !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_mem got=%h exp=dead55ef", mem[4]); end
        do_req(OP_SH, 32'h12, 32'h0000A5C3);
        checks++; if (mem[4] !== 32'hA5C355EF) begin errors++; $display("FAIL sh_mem got=%h exp=a5c355ef", mem[4]); end
    endtask

    task automatic test_load_ext();
        do_req(OP_SW, 32'h10, 32'h8081F0FF);
        do_req(OP_LB, 32'h10, 32'h0);
        checks++; if (got_rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb got=%h exp=ffffffff", got_rd); end
        do_req(OP_LBU, 32'h12, 32'h0);
        checks++; if (got_rd !== 32'h00000081) begin errors++; $display("FAIL lbu got=%h exp=00000081", got_rd); end
        do_req(OP_LH, 32'h12, 32'h0);
        checks++; if (got_rd !== 32'hFFFF8081) begin errors++; $display("FAIL lh got=%h exp=ffff8081", got_rd); end
        do_req(OP_LHU, 32'h10, 32'h0);
        checks++; if (got_rd !== 32'h0000F0FF) begin errors++; $display("FAIL lhu got=%h exp=0000f0ff", got_rd); end
        do_req(OP_LB, 32'h13, 32'h0);
        checks++; if (got_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb3 got=%h exp=ffffff80", got_rd); end
        // Held from the last DONE until the next one.
        @(negedge clk);
        checks++; if (resp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL rdata_hold got=%h exp=ffffff80", resp_rdata); end
    endtask

    task automatic test_errors();
        logic [3:0]  ops   [4] = '{OP_LW, OP_SH, OP_ILL, OP_LW};
        logic [31:0] addrs [4] = '{32'h13, 32'h11, 32'h10, 32'h400};
        for (int i = 0; i < 4; i++) begin
            do_req(ops[i], addrs[i], 32'h12345678);
            checks++; if (got_err !== 1'b1 || v_cyc !== 1) begin errors++; $display("FAIL err%0d_resp got=%b/%0d exp=1/1", i, got_err, v_cyc); end
            checks++; if (r_cnt !== 0 || w_cnt !== 0) begin errors++; $display("FAIL err%0d_strobes got=%0d/%0d exp=0/0", i, r_cnt, w_cnt); end
            checks++; if (mem[4] !== 32'h8081F0FF || got_rd !== 32'h0) begin errors++; $display("FAIL err%0d_mem got=%h/%h exp=8081f0ff/0", i, mem[4], got_rd); end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int vcnt;
        int wcnt;
        guard = 0; vcnt = 0; wcnt = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h11; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (dm_ctrl_r !== 1'b0 || dm_ctrl_w !== 1'b0) begin errors++; $display("FAIL rstmid_strobes got=%b%b exp=00", dm_ctrl_r, dm_ctrl_w); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got=%b/%b exp=1/0", req_ready, resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) vcnt++;
            if (dm_ctrl_w) wcnt++;
        end
        $display("reset mid-op: resp_pulses=%0d writes=%0d mem4=%h", vcnt, wcnt, mem[4]);
        checks++; if (vcnt !== 0 || wcnt !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0", vcnt, wcnt); end
        checks++; if (mem[4] !== 32'h8081F0FF) begin errors++; $display("FAIL rstmid_mem got=%h exp=8081f0ff", mem[4]); end
        do_req(OP_LW, 32'h10, 32'h0);
        checks++; if (got_rd !== 32'h8081F0FF || v_cyc !== 3) begin errors++; $display("FAIL rstmid_next got=%h/%0d exp=8081f0ff/3", got_rd, v_cyc); end
    endtask

    task automatic test_back_to_back();
        int pulse [3];
        int n;
        int guard;
        n = 0; guard = 0;
        pulse[0] = -1; pulse[1] = -1; pulse[2] = -1;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h20; req_wdata = 32'h11111111;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (n < 3) pulse[n] = k;
                n++;
                if (n == 1) begin req_addr = 32'h24; req_wdata = 32'h22222222; end
                if (n == 2) begin req_addr = 32'h28; req_wdata = 32'h33333333; end
                if (n == 3) req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        $display("back-to-back: pulses=%0d at %0d %0d %0d", n, pulse[0], pulse[1], pulse[2]);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n); end
        checks++; if (pulse[0] !== 2 || pulse[1] !== 5 || pulse[2] !== 8) begin errors++; $display("FAIL b2b_timing got=%0d,%0d,%0d exp=2,5,8", pulse[0], pulse[1], pulse[2]); end
        checks++; if (mem[8] !== 32'h11111111 || mem[9] !== 32'h22222222 || mem[10] !== 32'h33333333) begin
            errors++; $display("FAIL b2b_mem got=%h,%h,%h exp=11111111,22222222,33333333", mem[8], mem[9], mem[10]);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_sb_rmw();
        test_load_ext();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
